// File: rtl/md_issue_ctrl.sv
// E-stage issue and hazard control for the HI/LO multiply/divide unit.
// Optional stall statistics counter is built when MD_STALL_CNT_EN is defined.
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic        flush_e,
    input  logic        d_md_use,
    output logic [3:0]  hilo_op,
    output logic        start,
    output logic        md_busy,
    output logic        stall_d,
    output logic        err,
    output logic [31:0] stall_cnt
);

    logic       busy_q, busy_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       kill_s, issue_s, viol_s;

    // Decode E-stage op against the shadow busy window.
    always_comb begin
        kill_s  = flush_e | ~e_valid | e_md_op[3];
        issue_s = ~kill_s & ~busy_q & (e_md_op[3:2] == 2'b01);
        viol_s  = e_valid & ~flush_e & busy_q & ~e_md_op[3];
    end

    // State register for the busy shadow and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    // Next-state: load latency on issue, count down, release on the unit's write edge.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        err_d  = err_q | viol_s;
        if (issue_s) begin
            busy_d = 1'b1;
            cnt_d  = e_md_op[0] ? 4'(DIV_LAT) : 4'(MULT_LAT);
        end else if (busy_q) begin
            if (cnt_q == 4'd1) begin
                busy_d = 1'b0;
                cnt_d  = 4'd0;
            end else begin
                busy_d = 1'b1;
                cnt_d  = cnt_q - 4'd1;
            end
        end else begin
            busy_d = 1'b0;
            cnt_d  = 4'd0;
        end
    end

    // Outputs: killed or colliding ops are replaced by the idle code.
    always_comb begin
        if (kill_s || busy_q) begin
            hilo_op = 4'b1111;
        end else begin
            hilo_op = e_md_op;
        end
        start   = issue_s;
        stall_d = d_md_use & (busy_q | issue_s);
        md_busy = busy_q;
        err     = err_q;
    end

`ifdef MD_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating stall counter next value.
    always_comb begin
        if (stall_d && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed steps then random traffic against a
// cycle-numbered reference model of the busy window.
module tb_md_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        e_valid;
    logic [3:0]  e_md_op;
    logic        flush_e;
    logic        d_md_use;
    logic [3:0]  hilo_op;
    logic        start;
    logic        md_busy;
    logic        stall_d;
    logic        err;
    logic [31:0] stall_cnt;

    int tests = 0;
    int fails = 0;

    // Reference model: busy is "current cycle number is within the issued window".
    int     cyc      = 0;
    int     busy_end = -1000;
    bit     m_err    = 1'b0;
    longint m_scnt   = 0;

    md_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_md_op(e_md_op),
        .flush_e(flush_e), .d_md_use(d_md_use), .hilo_op(hilo_op),
        .start(start), .md_busy(md_busy), .stall_d(stall_d), .err(err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; e_valid = 1'b0; e_md_op = 4'hF; flush_e = 1'b0; d_md_use = 1'b0;
        @(posedge clk); #1;
        reset    = 1'b0;
        cyc++;
        busy_end = -1000;
        m_err    = 1'b0;
        m_scnt   = 0;
    endtask

    // One clock cycle: drive, check combinational and registered outputs, advance model.
    task automatic cycle(input bit v, input logic [3:0] op, input bit fl, input bit du);
        bit   m_busy, m_kill, m_issue, m_stall;
        logic [3:0] m_hilo;
        int   lat;
        e_valid = v; e_md_op = op; flush_e = fl; d_md_use = du;
        #3;
        m_busy  = (cyc <= busy_end);
        m_kill  = fl || !v || (op >= 4'd8);
        m_issue = !m_kill && !m_busy && (op >= 4'd4) && (op <= 4'd7);
        m_hilo  = (m_kill || m_busy) ? 4'hF : op;
        m_stall = du && (m_busy || m_issue);
        lat     = (op % 2 == 0) ? 5 : 10;
        chk("hilo_op", {28'd0, hilo_op}, {28'd0, m_hilo});
        chk("start", {31'd0, start}, {31'd0, m_issue});
        chk("md_busy", {31'd0, md_busy}, {31'd0, m_busy});
        chk("stall_d", {31'd0, stall_d}, {31'd0, m_stall});
        chk("err", {31'd0, err}, {31'd0, m_err});
`ifdef MD_STALL_CNT_EN
        chk("stall_cnt", stall_cnt, m_scnt[31:0]);
`else
        chk("stall_cnt", stall_cnt, 32'h0000_0000);
`endif
        @(posedge clk); #1;
        if (m_issue) busy_end = cyc + lat;
        if (v && !fl && m_busy && (op < 4'd8)) m_err = 1'b1;
        if (m_stall && m_scnt < 64'hFFFF_FFFF) m_scnt++;
        cyc++;
    endtask

    initial begin
        logic [3:0] rop;
        do_reset();
        chk("rst_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_hilo", {28'd0, hilo_op}, 32'hF);

        // MULT issue, then idle through the busy window
        cycle(1'b1, 4'b0110, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 4'hF, 1'b0, 1'b0);

        // DIVU with a D-stage MD op waiting
        cycle(1'b1, 4'b0101, 1'b0, 1'b1);
        for (int i = 0; i < 11; i++) cycle(1'b0, 4'hF, 1'b0, 1'b1);

        // MFLO while idle
        cycle(1'b1, 4'b0001, 1'b0, 1'b0);

        // MTHI forced in while busy, err sticks
        cycle(1'b1, 4'b0110, 1'b0, 1'b0);
        cycle(1'b1, 4'b0010, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 4'hF, 1'b0, 1'b0);
        chk("err_sticky", {31'd0, err}, 32'd1);

        // Flushed MULT, then flush mid-divide
        do_reset();
        cycle(1'b1, 4'b0110, 1'b1, 1'b0);
        cycle(1'b0, 4'hF, 1'b0, 1'b0);
        cycle(1'b1, 4'b0111, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) cycle(i % 3 == 0, 4'b0100, i % 2 == 0, 1'b0);

        // Back-to-back MULT then MFHI held in D
        do_reset();
        cycle(1'b1, 4'b0110, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'hF, 1'b0, 1'b1);
        cycle(1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef MD_STALL_CNT_EN
        chk("scnt_six", stall_cnt, 32'd6);
`endif

        // Reset mid-operation
        cycle(1'b1, 4'b0111, 1'b0, 1'b1);
        cycle(1'b0, 4'hF, 1'b0, 1'b1);
        do_reset();
        chk("rst_mid_busy", {31'd0, md_busy}, 32'd0);
        chk("rst_mid_scnt", stall_cnt, 32'd0);
        cycle(1'b0, 4'hF, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                rop = ($urandom_range(0, 8) == 8) ? 4'hF : 4'($urandom_range(0, 7));
                cycle(($urandom_range(0, 3) != 0), rop,
                      ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
